// File: rtl/trace_vector_packer.sv
// Packs M-lane trace beats into N-lane vectors for the input buffer, with
// end-of-frame flush/discard handling and tracing-gated capture.
module trace_vector_packer #(
  parameter int             N          = 8,
  parameter int             M          = 2,
  parameter int             DATA_WIDTH = 32,
  parameter logic [7:0]     PACKER_ID  = 8'd1,
  parameter bit             INIT_FLUSH = 1'b1,
  localparam int            BEATS      = N / M,
  localparam int            CW         = $clog2(BEATS) + 1
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             tracing,
  input  logic                             beat_valid,
  input  logic [M-1:0][DATA_WIDTH-1:0]     beat_in,
  input  logic                             eof_in,
  input  logic [7:0]                       configId,
  input  logic [7:0]                       configData,
  output logic                             enqueue,
  output logic [N-1:0][DATA_WIDTH-1:0]     vector_out,
  output logic                             eof_out,
  output logic [CW-1:0]                    beat_count
);

  logic [N-1:0][DATA_WIDTH-1:0] part_q, part_nxt, merged, vec_nxt;
  logic [CW-1:0]                count_nxt;
  logic                         flush_q, enq_nxt, eof_nxt;

  // Lanes above the current beat count are always zero in part_q, so an
  // emitted partial vector is zero-padded for free.
  always_comb begin
    merged = part_q;
    for (int k = 0; k < BEATS; k++) begin
      if (beat_count == CW'(k)) begin
        for (int l = 0; l < M; l++) merged[k*M+l] = beat_in[l];
      end
    end
  end

  always_comb begin
    part_nxt  = part_q;
    count_nxt = beat_count;
    vec_nxt   = vector_out;
    enq_nxt   = 1'b0;
    eof_nxt   = 1'b0;
    if (!tracing) begin
      part_nxt  = '0;
      count_nxt = '0;
      eof_nxt   = eof_in;
    end else if (beat_valid) begin
      if (beat_count == CW'(BEATS - 1)) begin
        enq_nxt   = 1'b1;
        vec_nxt   = merged;
        eof_nxt   = eof_in;
        part_nxt  = '0;
        count_nxt = '0;
      end else if (eof_in) begin
        eof_nxt   = 1'b1;
        enq_nxt   = flush_q;
        if (flush_q) vec_nxt = merged;
        part_nxt  = '0;
        count_nxt = '0;
      end else begin
        part_nxt  = merged;
        count_nxt = beat_count + CW'(1);
      end
    end else if (eof_in) begin
      eof_nxt = 1'b1;
      if (flush_q && beat_count != '0) begin
        enq_nxt = 1'b1;
        vec_nxt = part_q;
      end
      part_nxt  = '0;
      count_nxt = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      part_q     <= '0;
      beat_count <= '0;
      vector_out <= '0;
      enqueue    <= 1'b0;
      eof_out    <= 1'b0;
      flush_q    <= INIT_FLUSH;
    end else begin
      part_q     <= part_nxt;
      beat_count <= count_nxt;
      vector_out <= vec_nxt;
      enqueue    <= enq_nxt;
      eof_out    <= eof_nxt;
      if (configId == PACKER_ID) flush_q <= configData[0];
    end
  end

endmodule
